// File: rtl/simon_sequencer.sv
// Simon-style colour sequence store: appends random 2-bit steps, plays them back over a
// valid/ready channel and checks player button presses against the stored sequence.
module simon_sequencer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   rand_in,
  output logic          lfsr_step,
  input  logic          clear,
  input  logic          append,
  input  logic          play_start,
  input  logic          check_start,
  output logic          out_valid,
  output logic [1:0]    out_color,
  input  logic          out_ready,
  input  logic          in_valid,
  input  logic [1:0]    in_color,
  output logic [LW-1:0] len,
  output logic          full,
  output logic          busy,
  output logic          result_ok,
  output logic          result_fail
);

  localparam int unsigned IW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StCheck
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic                 ok_q, ok_d;
  logic                 fail_q, fail_d;
  logic [2*MAX_LEN-1:0] store_q;

  logic                 wr_en;
  logic [IW-1:0]        rd_ptr;
  logic [IW-1:0]        wr_ptr;
  logic [1:0]           cur_step;
  logic                 last_idx;
  logic                 unused_rand;

  // Only the two LSBs of the upstream LFSR state pick the colour.
  assign unused_rand = ^rand_in[31:2];

  assign full     = (len_q == LW'(MAX_LEN));
  assign rd_ptr   = idx_q[IW-1:0];
  assign wr_ptr   = len_q[IW-1:0];
  assign cur_step = store_q[{rd_ptr, 1'b0} +: 2];
  assign last_idx = (idx_q == len_q - 1'b1);

  // Highest-priority active command in IDLE decides; a blocked append must not step the LFSR.
  assign wr_en = (state_q == StIdle) && !clear && append && !full;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ok_d    = 1'b0;
    fail_d  = 1'b0;

    if (clear) begin
      state_d = StIdle;
      len_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (append) begin
            if (!full) begin
              len_d = len_q + 1'b1;
            end
          end else if (play_start) begin
            if (len_q != '0) begin
              idx_d   = '0;
              state_d = StPlay;
            end
          end else if (check_start) begin
            if (len_q != '0) begin
              idx_d   = '0;
              state_d = StCheck;
            end
          end
        end

        StPlay: begin
          if (out_ready) begin
            if (last_idx) begin
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        StCheck: begin
          if (in_valid) begin
            if (in_color != cur_step) begin
              fail_d  = 1'b1;
              state_d = StIdle;
            end else if (last_idx) begin
              ok_d    = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  // Store is never reset: reads are confined to indices below len.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store_q[{wr_ptr, 1'b0} +: 2] <= rand_in[1:0];
    end
  end

  assign lfsr_step   = rst_n & wr_en;
  assign out_valid   = (state_q == StPlay);
  assign out_color   = out_valid ? cur_step : 2'b00;
  assign busy        = (state_q != StIdle);
  assign len         = len_q;
  assign result_ok   = ok_q;
  assign result_fail = fail_q;

endmodule
